// File: rtl/rgmii_tx_ddr_gen.sv
// rgmii_tx_ddr_gen
// Multi-lane RGMII transmit generator. Turns per-lane GMII bytes into
// registered DDR launch pairs (d1 = rising half, d2 = falling half) for
// downstream ODDR primitives driving TXC, TD and TX_CTL. All lanes share
// one TXC timebase. At 10/100 each byte is sent as two nibble periods
// (low nibble first) of DIV_100M / DIV_10M clk cycles each.
//
// Ports:
//   clk              gmii_gtx_clk (125 MHz)
//   rst              asynchronous active-high reset
//   speed            requested speed: 10 = 1G, 01 = 100M, 00 = 10M, 11 = 1G
//   gmii_txd         per-lane TX byte, lane k at [8k+7:8k]
//   gmii_tx_en       per-lane TX enable
//   gmii_tx_er       per-lane TX error
//   gmii_tx_clk_en   combinational byte strobe (byte taken on edges where 1)
//   speed_active     speed currently in effect
//   txc_d1/txc_d2    TXC rising/falling-half launch values
//   td_d1/td_d2      TD rising/falling-half, lane k at [4k+3:4k]
//   tx_ctl_d1/_d2    TX_CTL rising/falling-half, one bit per lane
module rgmii_tx_ddr_gen #(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned DIV_100M = 5,
    parameter int unsigned DIV_10M  = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              speed,
    input  logic [8*CHANNELS-1:0]   gmii_txd,
    input  logic [CHANNELS-1:0]     gmii_tx_en,
    input  logic [CHANNELS-1:0]     gmii_tx_er,
    output logic                    gmii_tx_clk_en,
    output logic [1:0]              speed_active,
    output logic                    txc_d1,
    output logic                    txc_d2,
    output logic [4*CHANNELS-1:0]   td_d1,
    output logic [4*CHANNELS-1:0]   td_d2,
    output logic [CHANNELS-1:0]     tx_ctl_d1,
    output logic [CHANNELS-1:0]     tx_ctl_d2
);

    localparam int unsigned DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
    localparam int unsigned CNT_W   = $clog2(DIV_MAX);

    logic                  init;
    logic [CNT_W-1:0]      cnt;
    logic                  nib;
    logic [4*CHANNELS-1:0] hold_nib;
    logic [CHANNELS-1:0]   hold_en;
    logic [CHANNELS-1:0]   hold_er;

    logic [31:0] div_cur;
    logic [31:0] cnt_next;
    logic        last_cnt;
    logic        boundary;
    logic        txc_inc_d1;
    logic        txc_inc_d2;

    // Nibble-period length and TXC shape for the next count value.
    always_comb begin
        div_cur    = (speed_active == 2'b00) ? 32'(DIV_10M) : 32'(DIV_100M);
        cnt_next   = 32'(cnt) + 32'd1;
        last_cnt   = (32'(cnt) == (div_cur - 32'd1));
        // TXC high while 2c < N (half-cycle resolution gives exact 50% duty)
        txc_inc_d1 = ((cnt_next << 1) < div_cur);
        txc_inc_d2 = (((cnt_next << 1) + 32'd1) < div_cur);
    end

    // Byte boundary: every cycle at 1G, end of second nibble at 10/100.
    assign boundary       = init | speed_active[1] | (last_cnt & nib);
    assign gmii_tx_clk_en = boundary;

    // Timebase, hold registers and registered DDR launch pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init         <= 1'b1;
            speed_active <= 2'b10;
            cnt          <= '0;
            nib          <= 1'b0;
            hold_nib     <= '0;
            hold_en      <= '0;
            hold_er      <= '0;
            txc_d1       <= 1'b1;
            txc_d2       <= 1'b0;
            td_d1        <= '0;
            td_d2        <= '0;
            tx_ctl_d1    <= '0;
            tx_ctl_d2    <= '0;
        end else if (boundary) begin
            init         <= 1'b0;
            speed_active <= speed;
            cnt          <= '0;
            nib          <= 1'b0;
            hold_en      <= gmii_tx_en;
            hold_er      <= gmii_tx_er;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                hold_nib[4*k +: 4] <= gmii_txd[8*k+4 +: 4];
            end
            if (speed[1]) begin
                txc_d1    <= 1'b1;
                txc_d2    <= 1'b0;
                tx_ctl_d1 <= gmii_tx_en;
                tx_ctl_d2 <= gmii_tx_en ^ gmii_tx_er;
                for (int k = 0; k < int'(CHANNELS); k++) begin
                    td_d1[4*k +: 4] <= gmii_txd[8*k +: 4];
                    td_d2[4*k +: 4] <= gmii_txd[8*k+4 +: 4];
                end
            end else begin
                // Count restarts at 0, so TXC is high in both halves.
                txc_d1    <= 1'b1;
                txc_d2    <= 1'b1;
                tx_ctl_d1 <= gmii_tx_en;
                tx_ctl_d2 <= gmii_tx_en;
                for (int k = 0; k < int'(CHANNELS); k++) begin
                    td_d1[4*k +: 4] <= gmii_txd[8*k +: 4];
                    td_d2[4*k +: 4] <= gmii_txd[8*k +: 4];
                end
            end
        end else if (last_cnt) begin
            // End of low nibble: launch the held high nibble.
            nib       <= 1'b1;
            cnt       <= '0;
            txc_d1    <= 1'b1;
            txc_d2    <= 1'b1;
            td_d1     <= hold_nib;
            td_d2     <= hold_nib;
            tx_ctl_d1 <= hold_en;
            tx_ctl_d2 <= hold_en;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            txc_d1    <= txc_inc_d1;
            txc_d2    <= txc_inc_d2;
            tx_ctl_d1 <= txc_inc_d1 ? hold_en : (hold_en ^ hold_er);
            tx_ctl_d2 <= txc_inc_d2 ? hold_en : (hold_en ^ hold_er);
        end
    end

endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// Bench for rgmii_tx_ddr_gen with two lanes. A byte-level model expands each
// accepted byte into its full list of expected output cycles; a compare
// process checks every cycle, and directed scenarios add literal checks.
module tb_rgmii_tx_ddr_gen;

    localparam int unsigned CH  = 2;
    localparam int unsigned D100 = 5;
    localparam int unsigned D10  = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    speed;
    logic [15:0]   gmii_txd;
    logic [1:0]    gmii_tx_en;
    logic [1:0]    gmii_tx_er;
    logic          gmii_tx_clk_en;
    logic [1:0]    speed_active;
    logic          txc_d1, txc_d2;
    logic [7:0]    td_d1, td_d2;
    logic [1:0]    tx_ctl_d1, tx_ctl_d2;

    int errors = 0;
    int checks = 0;

    rgmii_tx_ddr_gen #(.CHANNELS(CH), .DIV_100M(D100), .DIV_10M(D10)) dut (
        .clk(clk), .rst(rst), .speed(speed),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_tx_clk_en(gmii_tx_clk_en), .speed_active(speed_active),
        .txc_d1(txc_d1), .txc_d2(txc_d2), .td_d1(td_d1), .td_d2(td_d2),
        .tx_ctl_d1(tx_ctl_d1), .tx_ctl_d2(tx_ctl_d2)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic       t1;
        logic       t2;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] c1;
        logic [1:0] c2;
    } samp_t;

    samp_t      q[$];
    samp_t      cur;
    logic [1:0] m_speed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic samp_t reset_samp();
        samp_t s;
        s.t1 = 1'b1; s.t2 = 1'b0; s.d1 = '0; s.d2 = '0; s.c1 = '0; s.c2 = '0;
        return s;
    endfunction

    // Expand one accepted byte into every output cycle it occupies.
    task automatic expand(input logic [1:0] sp, input logic [15:0] d,
                          input logic [1:0] e, input logic [1:0] r);
        samp_t s;
        int n;
        if (sp[1]) begin
            s.t1 = 1'b1; s.t2 = 1'b0;
            s.d1 = {d[11:8], d[3:0]};
            s.d2 = {d[15:12], d[7:4]};
            s.c1 = e; s.c2 = e ^ r;
            q.push_back(s);
        end else begin
            n = (sp == 2'b00) ? int'(D10) : int'(D100);
            for (int i = 0; i < 2*n; i++) begin
                int c;
                c = i % n;
                s.t1 = (2*c < n);
                s.t2 = (2*c + 1 < n);
                s.d1 = (i < n) ? {d[11:8], d[3:0]} : {d[15:12], d[7:4]};
                s.d2 = s.d1;
                s.c1 = s.t1 ? e : (e ^ r);
                s.c2 = s.t2 ? e : (e ^ r);
                q.push_back(s);
            end
        end
    endtask

    // Model: a new byte is accepted whenever the previous one is fully sent.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur     = reset_samp();
            m_speed = 2'b10;
        end else begin
            if (q.size() == 0) begin
                m_speed = speed;
                expand(speed, gmii_txd, gmii_tx_en, gmii_tx_er);
            end
            cur = q.pop_front();
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("clk_en", 32'(gmii_tx_clk_en), 32'(rst || q.size() == 0));
        check("speed_active", 32'(speed_active), 32'(m_speed));
        check("txc", 32'({txc_d1, txc_d2}), 32'({cur.t1, cur.t2}));
        check("td_d1", 32'(td_d1), 32'(cur.d1));
        check("td_d2", 32'(td_d2), 32'(cur.d2));
        check("ctl_d1", 32'(tx_ctl_d1), 32'(cur.c1));
        check("ctl_d2", 32'(tx_ctl_d2), 32'(cur.c2));
    end

    // Present a byte and return at the negedge after the edge that took it.
    task automatic send(input logic [15:0] d, input logic [1:0] e, input logic [1:0] r);
        int n;
        logic ce;
        gmii_txd = d; gmii_tx_en = e; gmii_tx_er = r;
        n = 0;
        do begin
            ce = gmii_tx_clk_en;
            @(negedge clk);
            n++;
        end while (!ce && n < 300);
        check("send_accept", 32'(ce), 32'd1);
    endtask

    // Cycles between two consecutive strobe pulses.
    task automatic measure_period(output int p);
        int n;
        n = 0;
        while (!gmii_tx_clk_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        p = 1;
        while (!gmii_tx_clk_en && p < 300) begin
            @(negedge clk);
            p++;
        end
    endtask

    task automatic check_1g_literals(input string tag);
        check({tag, "_txc"}, 32'({txc_d1, txc_d2}), 32'h2);
        check({tag, "_td_d1"}, 32'(td_d1), 32'h3A);
        check({tag, "_td_d2"}, 32'(td_d2), 32'hC5);
        check({tag, "_ctl_d1"}, 32'(tx_ctl_d1), 32'h3);
        check({tag, "_ctl_d2"}, 32'(tx_ctl_d2), 32'h1);
    endtask

    initial begin
        int p;
        int ones1, ones2;
        int n;
        logic [1:0] txc_tab [0:4];
        txc_tab[0] = 2'b11; txc_tab[1] = 2'b11; txc_tab[2] = 2'b10;
        txc_tab[3] = 2'b00; txc_tab[4] = 2'b00;

        rst = 1'b0; speed = 2'b10; gmii_txd = '0; gmii_tx_en = '0; gmii_tx_er = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txc", 32'({txc_d1, txc_d2}), 32'h2);
        check("rst_speed", 32'(speed_active), 32'h2);
        check("rst_clk_en", 32'(gmii_tx_clk_en), 32'h1);
        rst = 1'b0;

        // 1G: lane0 0x5A en/er=1/0, lane1 0xC3 en/er=1/1
        send(16'hC35A, 2'b11, 2'b10);
        check_1g_literals("g1");
        measure_period(p);
        check("g1_period", 32'(p), 32'd1);

        // 100M: lane0 0x3C en=1 er=1
        speed = 2'b01;
        send(16'h003C, 2'b01, 2'b01);
        for (int i = 0; i < 10; i++) begin
            check("m100_txc", 32'({txc_d1, txc_d2}), 32'(txc_tab[i % 5]));
            check("m100_td", 32'(td_d1[3:0]), (i < 5) ? 32'hC : 32'h3);
            check("m100_ctl", 32'({tx_ctl_d1[0], tx_ctl_d2[0]}), 32'(txc_tab[i % 5]));
            @(negedge clk);
        end
        measure_period(p);
        check("m100_period", 32'(p), 32'd10);

        // Switch to 1G requested while cnt=2 of the low nibble.
        repeat (3) @(negedge clk);
        speed = 2'b10;
        n = 0;
        while (speed_active == 2'b01 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("switch_defer", 32'(n), 32'd8);
        check("switch_speed", 32'(speed_active), 32'h2);

        // 10M
        speed = 2'b00;
        send(16'h00A5, 2'b01, 2'b00);
        ones1 = 0; ones2 = 0;
        for (int i = 0; i < 50; i++) begin
            ones1 += int'(txc_d1);
            ones2 += int'(txc_d2);
            @(negedge clk);
        end
        check("m10_txc_d1_high", 32'(ones1), 32'd25);
        check("m10_txc_d2_high", 32'(ones2), 32'd25);
        measure_period(p);
        check("m10_period", 32'(p), 32'd100);

        // Reset mid-nibble at 10M.
        repeat (17) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_txc", 32'({txc_d1, txc_d2}), 32'h2);
        check("arst_td", 32'({td_d1, td_d2}), 32'h0);
        check("arst_ctl", 32'({tx_ctl_d1, tx_ctl_d2}), 32'h0);
        check("arst_speed", 32'(speed_active), 32'h2);
        check("arst_clk_en", 32'(gmii_tx_clk_en), 32'h1);
        repeat (2) @(negedge clk);
        speed = 2'b00; gmii_txd = 16'h0096; gmii_tx_en = 2'b01; gmii_tx_er = 2'b00;
        rst = 1'b0;
        check("rel_clk_en", 32'(gmii_tx_clk_en), 32'h1);
        @(negedge clk);
        check("rel_speed", 32'(speed_active), 32'h0);
        check("rel_td_d1", 32'(td_d1), 32'h06);
        check("rel_td_d2", 32'(td_d2), 32'h06);
        check("rel_txc", 32'({txc_d1, txc_d2}), 32'h3);
        check("rel_ctl", 32'({tx_ctl_d1, tx_ctl_d2}), 32'h5);

        // speed=11 behaves as 1G
        speed = 2'b11;
        send(16'hC35A, 2'b11, 2'b10);
        check_1g_literals("g11");
        check("g11_speed", 32'(speed_active), 32'h3);
        measure_period(p);
        check("g11_period", 32'(p), 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_ddr_gen.md
Name: rgmii_tx_ddr_gen

Overview:
Multi-lane RGMII transmit generator. It converts per-lane GMII byte streams into registered DDR launch pairs (d1 on the rising half-cycle, d2 on the falling half-cycle) for downstream ODDR primitives, covering TXC, TD and TX_CTL. It sits between the MAC TX datapath and the ODDR/IO layer, in the gmii_gtx_clk domain.
Unlike the single-lane nibble-fed interface, it supports CHANNELS lanes sharing one TXC timebase. At 10/100 it takes full bytes from the MAC and sequences the two nibbles internally, with parametrised dividers and glitch-free speed switching.

Parameters:
CHANNELS, 1, number of lanes sharing one TXC timebase (>=1)
DIV_100M, 5, gtx_clk cycles per nibble period at 100M (>=2)
DIV_10M, 50, gtx_clk cycles per nibble period at 10M (>=2)

Ports:
clk  input  1  gmii_gtx_clk, 125 MHz
rst  input  1  asynchronous, active-high reset
speed  input  2  requested speed: 2'b10 1G, 2'b01 100M, 2'b00 10M, 2'b11 treated as 1G
gmii_txd  input  8*CHANNELS  per-lane TX byte, lane k at [8k+7:8k]
gmii_tx_en  input  CHANNELS  per-lane TX enable
gmii_tx_er  input  CHANNELS  per-lane TX error
gmii_tx_clk_en  output  1  combinational byte strobe; the MAC presents a new byte on every clk edge where this is 1
speed_active  output  2  speed currently in effect
txc_d1  output  1  TXC rising-half launch value
txc_d2  output  1  TXC falling-half launch value
td_d1  output  4*CHANNELS  TD rising-half, lane k at [4k+3:4k]
td_d2  output  4*CHANNELS  TD falling-half
tx_ctl_d1  output  CHANNELS  TX_CTL rising-half
tx_ctl_d2  output  CHANNELS  TX_CTL falling-half

Behaviour:
- State:
  - init flag (reset 1)
  - speed_active (reset 2'b10)
  - cnt (0..N-1, reset 0), where N = DIV_100M or DIV_10M per speed_active
  - nib phase bit (reset 0)
  - per-lane hold register: high nibble, en, er (reset 0)
- Reset values: txc_d1=1, txc_d2=0, td_*=0, tx_ctl_*=0, speed_active=2'b10.
  - Async assert takes effect immediately, including mid-frame or mid-period.
  - The first edge after deassert is a boundary.
- Boundary condition B:
  - B = init OR speed_active is 1G OR (cnt==N-1 AND nib==1).
  - gmii_tx_clk_en = B (combinational); it is 1 while in reset.
- On every edge with B=1:
  - Clear init.
  - speed_active <= speed (speed changes take effect only here; a mid-byte change is deferred to the byte end).
  - cnt <= 0, nib <= 0.
  - Capture the inputs.
- 1G (new speed_active is 1G at the edge):
  - txc_d1=1, txc_d2=0.
  - td_d1=txd[3:0], td_d2=txd[7:4].
  - tx_ctl_d1=en, tx_ctl_d2=en^er.
  - Registered, latency 1 cycle. Byte accepted every cycle.
- 10/100, capture edge (B=1):
  - hold <= {txd[7:4], en, er}.
  - td_d1 = td_d2 = txd[3:0] (low nibble first).
  - ctl value computed from the captured en/er.
- 10/100, wrap edge with nib==0 (cnt==N-1):
  - nib <= 1, cnt <= 0.
  - td_d1 = td_d2 = hold nibble.
  - ctl uses the held en/er.
- 10/100, otherwise: cnt <= cnt+1; td is held.
- TXC at 10/100 (per output cycle, c = next cnt):
  - txc_d1 = (2c < N), txc_d2 = (2c+1 < N).
  - Gives exact 50% duty at half-cycle resolution; for N=5 the TXC fall is at half-cycle 5.
- TX_CTL at 10/100:
  - tx_ctl_dX = txc_dX ? en : en^er, for X=1,2, using the current nibble's en/er.
- Timing alignment: data changes on the same edge as the TXC rising half. Skew is supplied externally (clk90 or PHY delay), identical to 1G.
- Strobe rate: at 10/100, gmii_tx_clk_en pulses one cycle every 2N cycles.
- Lanes: all lanes share cnt/nib/TXC; lanes are otherwise independent.

Test Plan:
1. 1G, CHANNELS=2: lane0 drives 0x5A en=1 er=0 -> next cycle td_d1[3:0]=A, td_d2[3:0]=5, tx_ctl d1/d2=1/1, txc 1/0, clk_en constantly 1.
2. 100M, DIV_100M=5, byte 0x3C with en=1, er=1:
   - clk_en period is 10 cycles.
   - td=C for 5 cycles, then 3 for 5 cycles.
   - txc pairs per cycle: 11, 11, 10, 00, 00.
   - tx_ctl=1 when txc=1 and 0 when txc=0.
3. 10M, DIV_10M=50: clk_en pulse spacing is 100 cycles; txc high for exactly 25 cycles of each 50.
4. Speed switch 100M->1G requested at cnt=2, nib=0 -> speed_active stays 01 until the cycle with cnt=4, nib=1, then becomes 10; no TXC pulse shorter than 5 cycles appears.
5. Assert rst mid-nibble at 10M -> outputs go to reset values immediately. After release:
   - clk_en=1 on the first edge.
   - speed_active loads speed.
   - New byte low nibble appears 1 cycle later.
6. speed=2'b11 -> behaves exactly as 1G (scenario 1 results).
